serial_add8: RTL and testbench

- Bit-serial adder controller sitting directly upstream of the 1-bit adder stage.
- Accepts two parallel WIDTH-bit operands and feeds them LSB-first, one bit per clock, through a 1-bit full adder built from two half_add instances plus an OR gate.
- Holds the carry between bits in a flip-flop and reassembles the serial sum bits into a parallel result with carry-out.
- Used in the examination datapath wherever area matters more than latency.

---
 rtl/serial_add8.sv | 183 ++++++++++++++++++
 tb/tb_serial_add8.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add8.sv
// serial_add8 -- bit-serial adder controller.
//
// Takes two parallel WIDTH-bit operands on a start pulse, pushes them
// LSB-first through a 1-bit full adder (two half_add cells plus an OR),
// keeps the inter-bit carry in a flip-flop and rebuilds the parallel sum.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request pulse, sampled only in IDLE or DONE
//   sub    in   1      (only with SERIAL_ADD_SUB_EN) 1 = a-b, sampled with start
//   a, b   in   WIDTH  operands, sampled on the start-accept edge only
//   sum    out  WIDTH  registered result, held until the next result
//   cout   out  1      registered carry-out of the MSB (no-borrow when subtracting)
//   busy   out  1      high exactly while the FSM is in RUN
//   done   out  1      one-cycle pulse: sum/cout were just written
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// FSM is in IDLE or DONE; start in RUN is dropped, never queued. Each
// accepted request yields exactly one done pulse WIDTH+1 cycles later,
// unless rst intervenes, in which case it yields nothing.
//
// Optional feature macro: SERIAL_ADD_SUB_EN (adds the sub input).

module half_add (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_add8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic accept;
    logic last_bit;
    logic load_inv;
    logic ha0_s, ha0_c, ha1_s, ha1_c;
    logic carry_new;

    // Subtraction is a + ~b + 1: invert B on load and preset the carry.
`ifdef SERIAL_ADD_SUB_EN
    assign load_inv = sub;
`else
    assign load_inv = 1'b0;
`endif

    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Full adder on the current LSBs and the stored carry.
    half_add u_ha0 (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .s_o (ha0_s),
        .c_o (ha0_c)
    );

    half_add u_ha1 (
        .a_i (ha0_s),
        .b_i (carry_q),
        .s_o (ha1_s),
        .c_o (ha1_c)
    );

    assign carry_new = ha0_c | ha1_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values; all outputs leave through registers.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);

        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = load_inv ? ~b : b;
            carry_d = load_inv;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            r_sh_d  = {ha1_s, r_sh_q[WIDTH-1:1]};
            carry_d = carry_new;
            cnt_d   = cnt_q + CW'(1);
            // The final bit goes straight into sum alongside the shifted bits.
            if (last_bit) begin
                sum_d  = {ha1_s, r_sh_q[WIDTH-1:1]};
                cout_d = carry_new;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_add8.sv
// Testbench for serial_add8 (WIDTH=8). Inputs are driven and outputs sampled
// on the falling edge; the DUT acts on the rising edge.

module tb_serial_add8;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    logic [W:0]   exp_q[$];
    logic [W-1:0] last_sum;
    int           n_tests;
    int           n_fail;

    serial_add8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic sv);
        if (sv) return {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
        return {1'b0, av} + {1'b0, bv};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e[W-1:0]));
                check("cout", 32'(cout), 32'(e[W]));
                last_sum = e[W-1:0];
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        a     = av;
        b     = bv;
        start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub   = sv;
        exp_q.push_back(model(av, bv, sv));
`else
        exp_q.push_back(model(av, bv, 1'b0));
`endif
    endtask

    // One full operation with per-cycle busy/done timing checks.
    task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        @(negedge clk);
        drive_start(av, bv, sv);
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            check("busy", 32'(busy), 32'(c <= W));
            check("done", 32'(done), 32'(c == W + 1));
            if (c == 4) check("sum_hold", 32'(sum), 32'(last_sum));
            if (c == 1) start = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests  = 0;
        n_fail   = 0;
        last_sum = '0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic timing and value.
        run_add(8'h5A, 8'h3C, 1'b0);
        // Carry out of the MSB, then zeros.
        run_add(8'hFF, 8'h01, 1'b0);
        run_add(8'h00, 8'h00, 1'b0);

        // start re-pulsed during RUN is ignored and not queued.
        @(negedge clk);
        drive_start(8'h12, 8'h34, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check("ign_busy", 32'(busy), 32'(c <= W));
            check("ign_done", 32'(done), 32'(c == W + 1));
            if (c == 1) start = 1'b0;
            if (c == 4) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end
            if (c == 5) start = 1'b0;
        end

        // start held high: back-to-back accepts from DONE.
        @(negedge clk);
        drive_start(8'h01, 8'h01, 1'b0);
        exp_q.push_back(9'h002);
        exp_q.push_back(9'h002);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            check("b2b_done", 32'(done), 32'((c % 9 == 0) && (c <= 27)));
            check("b2b_busy", 32'(busy), 32'((c < 27) && (c % 9 != 0)));
            if (c == 19) start = 1'b0;
        end

        // Reset mid-operation aborts without a result.
        @(negedge clk);
        drive_start(8'hAA, 8'h55, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        exp_q.delete();
        last_sum = '0;
        #1;
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_done", 32'(done), 32'd0);
        end
        run_add(8'hAA, 8'h55, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_add(8'h10, 8'h01, 1'b1);
        run_add(8'h00, 8'h01, 1'b1);
        run_add(8'h37, 8'h37, 1'b1);
        run_add(8'h81, 8'h7F, 1'b0);
`endif

        // Random operands.
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_add(ra, rb, rs);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
